// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory/IO port between the CPU
// load/store path and a debug/loader engine.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cpu_req/write/addr/wdata -> cpu_rdata, cpu_ack   CPU requester
//   dbg_req/write/addr/wdata -> dbg_rdata, dbg_ack   debug requester
//   draddr, dwdata, dwrite, dread, drdata            memory side
//   owner               00 none, 01 cpu, 10 dbg (current transaction)
//
// The CPU has fixed priority; after STARVE_MAX consecutive losses the
// debug port wins one arbitration. Fields are latched at grant, so a
// requester changing them mid-transaction has no effect.
module dmem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_write,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] draddr,
    output logic [DW-1:0] dwdata,
    output logic          dwrite,
    output logic          dread,
    input  logic [DW-1:0] drdata,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_CPU    = 2'b01;
    localparam logic [1:0] OWN_DBG    = 2'b10;
    localparam logic [1:0] LAT_LAST   = 2'(RD_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state;
    logic [3:0]    starve_cnt;
    logic [1:0]    lat_cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          write_q;
    logic [1:0]    owner_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic grant_any;
    logic grant_dbg;
    logic in_access;
    logic in_done;

    // dbg wins when alone, or when it has lost STARVE_MAX times in a row.
    always_comb begin
        grant_any = cpu_req | dbg_req;
        grant_dbg = dbg_req & (~cpu_req | (starve_cnt == STARVE_LIM));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lat_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        state   <= ACCESS;
                        lat_cnt <= '0;
                        if (grant_dbg) begin
                            addr_q     <= dbg_addr;
                            wdata_q    <= dbg_wdata;
                            write_q    <= dbg_write;
                            owner_q    <= OWN_DBG;
                            starve_cnt <= '0;
                        end else begin
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            write_q <= cpu_write;
                            owner_q <= OWN_CPU;
                            // Only a contested CPU win counts as a dbg loss.
                            if (dbg_req && starve_cnt != 4'hf)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (write_q || lat_cnt == LAT_LAST) begin
                        state <= DONE;
                        if (!write_q) begin
                            if (owner_q == OWN_DBG)
                                dbg_rdata_q <= drdata;
                            else
                                cpu_rdata_q <= drdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    owner_q <= OWN_NONE;
                end
                default: begin
                    state   <= IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Strobes and acks are gated with reset so a reset cycle never
    // touches memory or completes a transaction.
    always_comb begin
        in_access = (state == ACCESS);
        in_done   = (state == DONE) & ~reset;
        dwrite    = in_access & write_q & ~reset;
        dread     = in_access & ~write_q & ~reset;
        draddr    = in_access ? addr_q : '0;
        dwdata    = (in_access & write_q) ? wdata_q : '0;
        cpu_ack   = in_done & (owner_q == OWN_CPU);
        dbg_ack   = in_done & (owner_q == OWN_DBG);
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        owner     = owner_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios followed by a randomized
// two-requester run checked against a transaction-level model.
module tb_dmem_port_arbiter;

    localparam int AW         = 16;
    localparam int DW         = 16;
    localparam int RD_LAT     = 3;
    localparam int STARVE_MAX = 4;
    localparam int NCYC       = 3000;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ack;
    logic          dbg_req, dbg_write;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic [AW-1:0] draddr;
    logic [DW-1:0] dwdata, drdata;
    logic          dwrite, dread;
    logic [1:0]    owner;

    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] mem [0:255];

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_write(dbg_write),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .draddr(draddr), .dwdata(dwdata), .dwrite(dwrite),
        .dread(dread), .drdata(drdata), .owner(owner)
    );

    // Simple zero-wait memory; the bench preloads it through ld_*.
    always @(posedge clock) begin
        if (dwrite)
            mem[draddr[7:0]] <= dwdata;
        else if (ld_en)
            mem[ld_addr] <= ld_data;
    end
    assign drdata = mem[draddr[7:0]];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Random-phase model state, indexed 0=cpu, 1=dbg.
    logic [DW-1:0] model_mem [0:255];
    bit            pend [2];
    bit            gnt  [2];
    bit            w    [2];
    bit            wl   [2];
    int            gc   [2];
    int            ackc [2];
    logic [7:0]    a    [2];
    logic [DW-1:0] d    [2];
    logic [DW-1:0] expd [2];

    initial begin
        int n_cpu;
        int got;
        int k;
        int starve;
        int free_at;
        int win;
        int bad;
        bit rq0, rq1;
        bit exp_ack, act_ack, exp_wr, exp_rd;
        logic [1:0] expo;
        logic [DW-1:0] act_rd;

        reset = 1'b1;
        cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        chk("rst_owner", owner, 0);
        chk("rst_strobes", {dwrite, dread}, 0);
        chk("rst_draddr", draddr, 0);
        chk("rst_acks", {cpu_ack, dbg_ack}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        reset = 1'b0;
        tick();

        // CPU store, dbg idle
        cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h00ab;
        tick();
        chk("st_dwrite", dwrite, 1);
        chk("st_dread", dread, 0);
        chk("st_draddr", draddr, 16'h0010);
        chk("st_dwdata", dwdata, 16'h00ab);
        chk("st_owner1", owner, 1);
        tick();
        chk("st_ack", cpu_ack, 1);
        chk("st_owner2", owner, 1);
        chk("st_dwrite_off", dwrite, 0);
        cpu_req = 0;
        tick();
        chk("st_idle_owner", owner, 0);
        chk("st_mem", mem[8'h10], 16'h00ab);

        // dbg load, latency RD_LAT
        poke(8'h20, 16'h1234);
        dbg_req = 1; dbg_write = 0; dbg_addr = 16'h0020;
        for (int i = 0; i < RD_LAT; i++) begin
            tick();
            chk("ld_dread", dread, 1);
            chk("ld_dwrite", dwrite, 0);
            chk("ld_noack", dbg_ack, 0);
        end
        tick();
        chk("ld_ack", dbg_ack, 1);
        chk("ld_rdata", dbg_rdata, 16'h1234);
        chk("ld_owner", owner, 2);
        dbg_req = 0;
        tick();

        // Simultaneous requests
        cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h1111;
        dbg_req = 1; dbg_write = 1; dbg_addr = 16'h0031; dbg_wdata = 16'h2222;
        tick();
        chk("sim_owner_cpu", owner, 1);
        tick();
        chk("sim_cpu_ack", {cpu_ack, dbg_ack}, 2'b10);
        cpu_req = 0;
        tick();
        chk("sim_gap", {owner, dbg_ack}, 0);
        tick();
        chk("sim_dbg_wr", {dwrite, owner}, 3'b110);
        chk("sim_dbg_addr", draddr, 16'h0031);
        tick();
        chk("sim_dbg_ack", {cpu_ack, dbg_ack}, 2'b01);
        dbg_req = 0;
        tick();
        chk("sim_mem", {mem[8'h30], mem[8'h31]}, 32'h1111_2222);

        // Starvation bound
        cpu_req = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h0005;
        dbg_req = 1; dbg_addr = 16'h0051; dbg_wdata = 16'h0006;
        n_cpu = 0;
        got = 0;
        for (int i = 0; i < 80 && got == 0; i++) begin
            tick();
            if (cpu_ack) n_cpu++;
            if (dbg_ack) got = 1;
        end
        chk("stv_dbg_seen", got, 1);
        chk("stv_cpu_count", n_cpu, STARVE_MAX);
        dbg_req = 0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick();
            if (cpu_ack) got = 1;
        end
        chk("stv_cpu_resume", got, 1);
        cpu_req = 0;
        tick();
        tick();

        // Reset mid-read
        poke(8'h40, 16'h5a5a);
        cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0040;
        tick();
        chk("rr_dread1", dread, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rr_dread_gated", dread, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_after", {cpu_ack, owner}, 0);
        chk("rr_rdata0", cpu_rdata, 0);
        k = 0;
        got = 0;
        for (int i = 1; i <= 12 && got == 0; i++) begin
            tick();
            if (cpu_ack) begin
                got = 1;
                k = i;
            end
        end
        chk("rr_lat", k, 1 + RD_LAT);
        chk("rr_rdata", cpu_rdata, 16'h5a5a);
        cpu_req = 0;
        tick();

        // Field change after grant
        poke(8'h04, 16'h0404);
        poke(8'h08, 16'h0808);
        cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0004;
        tick();
        cpu_addr = 16'h0008;
        for (int i = 0; i < RD_LAT; i++) begin
            chk("fc_draddr", draddr, 16'h0004);
            tick();
        end
        chk("fc_ack", cpu_ack, 1);
        chk("fc_rdata", cpu_rdata, 16'h0404);
        cpu_req = 0;
        tick();

        // Randomized run against a transaction-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = DW'($urandom);
            poke(8'(i), model_mem[i]);
        end
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; gnt[r] = 0; w[r] = 0; wl[r] = 0;
            gc[r] = 0; ackc[r] = 0; a[r] = '0; d[r] = '0; expd[r] = '0;
        end
        starve = 0;
        free_at = 0;
        for (int c = 0; c < NCYC; c++) begin
            for (int r = 0; r < 2; r++)
                if (gnt[r] && ackc[r] == c - 1) begin
                    gnt[r]  = 0;
                    pend[r] = 0;
                end
            expo = 2'b00;
            exp_wr = 0;
            exp_rd = 0;
            for (int r = 0; r < 2; r++) begin
                exp_ack = gnt[r] && ackc[r] == c;
                act_ack = (r == 0) ? cpu_ack : dbg_ack;
                act_rd  = (r == 0) ? cpu_rdata : dbg_rdata;
                chk(r == 0 ? "rnd_cpu_ack" : "rnd_dbg_ack", act_ack, exp_ack);
                if (exp_ack && !wl[r])
                    chk(r == 0 ? "rnd_cpu_rdata" : "rnd_dbg_rdata",
                        act_rd, expd[r]);
                if (gnt[r] && c > gc[r] && c <= ackc[r])
                    expo = (r == 0) ? 2'b01 : 2'b10;
                if (gnt[r] && c > gc[r] && c < ackc[r]) begin
                    if (wl[r]) exp_wr = 1;
                    else exp_rd = 1;
                end
            end
            chk("rnd_owner", owner, expo);
            chk("rnd_strobes", {dwrite, dread}, {exp_wr, exp_rd});

            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && c < NCYC - 30 && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1;
                    w[r] = 1'($urandom);
                    a[r] = 8'($urandom);
                    d[r] = DW'($urandom);
                end else if (gnt[r] && $urandom_range(0, 3) == 0) begin
                    w[r] = 1'($urandom);
                    a[r] = 8'($urandom);
                    d[r] = DW'($urandom);
                end
            end
            cpu_req = pend[0]; cpu_write = w[0];
            cpu_addr = {8'h00, a[0]}; cpu_wdata = d[0];
            dbg_req = pend[1]; dbg_write = w[1];
            dbg_addr = {8'h00, a[1]}; dbg_wdata = d[1];

            if (c >= free_at) begin
                rq0 = pend[0] && !gnt[0];
                rq1 = pend[1] && !gnt[1];
                win = -1;
                if (rq0 && rq1) begin
                    if (starve == STARVE_MAX) begin
                        win = 1;
                        starve = 0;
                    end else begin
                        win = 0;
                        if (starve < 15) starve++;
                    end
                end else if (rq1) begin
                    win = 1;
                    starve = 0;
                end else if (rq0) begin
                    win = 0;
                end
                if (win >= 0) begin
                    gnt[win]  = 1;
                    gc[win]   = c;
                    wl[win]   = w[win];
                    ackc[win] = c + (w[win] ? 2 : 1 + RD_LAT);
                    free_at   = ackc[win] + 1;
                    if (w[win]) model_mem[a[win]] = d[win];
                    else expd[win] = model_mem[a[win]];
                end
            end
            tick();
        end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== model_mem[i]) bad++;
        chk("rnd_mem_image", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
